// File: rtl/bound_flasher_monitor_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bound_flasher_monitor_if : lamp bus plus monitor status signals       |
// | Rev 1.0  initial release                                              |
// +-----------------------------------------------------------------------+
interface bound_flasher_monitor_if #(
   parameter int MAX_LED = 16,
   parameter int CNT_W   = 8
);
   localparam int c_CW = $clog2(MAX_LED + 1);

   logic [MAX_LED-1:0] led;
   logic [2:0]         phase;
   logic [c_CW-1:0]    lit_cnt;
   logic               seq_done;
   logic               err;
   logic [2:0]         err_code;
   logic [CNT_W-1:0]   kick_cnt;
   logic [CNT_W-1:0]   cycle_cnt;

   // Flasher / bench side: drives the lamps, observes monitor status.
   modport master (
      output led,
      input  phase, lit_cnt, seq_done, err, err_code, kick_cnt, cycle_cnt
   );

   // Monitor side.
   modport slave (
      input  led,
      output phase, lit_cnt, seq_done, err, err_code, kick_cnt, cycle_cnt
   );
endinterface
`default_nettype wire

// File: rtl/bound_flasher_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | bound_flasher_monitor : passive checker decoding the flasher LED bus  |
// | Rev 1.0  initial release                                              |
// +-----------------------------------------------------------------------+
module bound_flasher_monitor #(
   parameter int MAX_LED = 16,
   parameter int CNT_W   = 8
) (
   input  wire logic               clk,
   input  wire logic               rst_n,
   bound_flasher_monitor_if.slave  mon_if
);
   localparam int c_CW = $clog2(MAX_LED + 1);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_UP5  = 3'd1;
   localparam logic [2:0] c_DN0A = 3'd2;
   localparam logic [2:0] c_UP10 = 3'd3;
   localparam logic [2:0] c_DN5  = 3'd4;
   localparam logic [2:0] c_UP15 = 3'd5;
   localparam logic [2:0] c_DN0B = 3'd6;
   localparam logic [2:0] c_ERR  = 3'd7;

   localparam logic [2:0] c_E_NONE     = 3'd0;
   localparam logic [2:0] c_E_NOTTHERM = 3'd1;
   localparam logic [2:0] c_E_STEP     = 3'd2;
   localparam logic [2:0] c_E_STALL    = 3'd3;
   localparam logic [2:0] c_E_OVERRUN  = 3'd4;
   localparam logic [2:0] c_E_BADTURN  = 3'd5;

   // Turning points of the sequence: peaks of the up phases, floor of DN5.
   localparam logic [c_CW-1:0] c_PK5  = c_CW'(6);
   localparam logic [c_CW-1:0] c_PK10 = c_CW'(11);
   localparam logic [c_CW-1:0] c_PK15 = c_CW'(16);
   localparam logic [c_CW-1:0] c_FL5  = c_CW'(5);
   localparam logic [c_CW-1:0] c_ZERO = '0;

   logic [2:0]         r_phase;
   logic [c_CW-1:0]    r_prev;
   logic [c_CW-1:0]    r_lit;
   logic               r_done;
   logic               r_err;
   logic [2:0]         r_err_code;
   logic [CNT_W-1:0]   r_kick;
   logic [CNT_W-1:0]   r_cycle;

   logic [c_CW-1:0]    w_cnt;
   logic [MAX_LED-1:0] w_mask;
   logic               w_thermo;
   logic               w_up;
   logic               w_dn;
   logic               w_stall;
   logic               w_jump;
   logic [2:0]         w_phase_nx;
   logic [2:0]         w_code;
   logic               w_kick;
   logic               w_done;

   always_comb begin
      w_cnt  = '0;
      w_mask = '0;
      for (int i = 0; i < MAX_LED; i++) begin
         w_cnt = w_cnt + c_CW'(mon_if.led[i]);
      end
      for (int i = 0; i < MAX_LED; i++) begin
         w_mask[i] = (c_CW'(i) < w_cnt);
      end
   end

   assign w_thermo = (mon_if.led == w_mask);
   assign w_up     = (w_cnt == r_prev + c_CW'(1));
   assign w_dn     = (r_prev == w_cnt + c_CW'(1));
   assign w_stall  = (w_cnt == r_prev);
   assign w_jump   = !(w_up || w_dn || w_stall);

   // Past the error rules only a single up or down step remains possible.
   always_comb begin
      w_phase_nx = r_phase;
      w_code     = c_E_NONE;
      w_kick     = 1'b0;
      w_done     = 1'b0;
      if (r_phase != c_ERR) begin
         if (!w_thermo) begin
            w_code = c_E_NOTTHERM;
         end else if (w_jump) begin
            w_code = c_E_STEP;
         end else if (w_stall) begin
            if (r_phase != c_IDLE) w_code = c_E_STALL;
         end else begin
            case (r_phase)
               c_IDLE: begin
                  if (w_up) w_phase_nx = c_UP5;
               end
               c_UP5: begin
                  if (w_up) begin
                     if (w_cnt > c_PK5) w_code = c_E_OVERRUN;
                  end else if (r_prev == c_PK5) begin
                     w_phase_nx = c_DN0A;
                  end else begin
                     w_code = c_E_BADTURN;
                  end
               end
               c_DN0A: begin
                  if (w_up) begin
                     if (r_prev == c_ZERO) w_phase_nx = c_UP10;
                     else                  w_code     = c_E_BADTURN;
                  end
               end
               c_UP10: begin
                  if (w_up) begin
                     if (w_cnt > c_PK10) w_code = c_E_OVERRUN;
                  end else if (r_prev == c_PK10) begin
                     w_phase_nx = c_DN5;
                  end else begin
                     w_kick     = 1'b1;
                     w_phase_nx = c_DN0A;
                  end
               end
               c_DN5: begin
                  if (w_dn) begin
                     if (w_cnt < c_FL5) w_code = c_E_OVERRUN;
                  end else if (r_prev == c_FL5) begin
                     w_phase_nx = c_UP15;
                  end else begin
                     w_code = c_E_BADTURN;
                  end
               end
               c_UP15: begin
                  if (w_up) begin
                     if (w_cnt > c_PK15) w_code = c_E_OVERRUN;
                  end else if (r_prev == c_PK15) begin
                     w_phase_nx = c_DN0B;
                  end else begin
                     w_kick     = 1'b1;
                     w_phase_nx = c_DN5;
                  end
               end
               c_DN0B: begin
                  if (w_up) begin
                     w_code = c_E_BADTURN;
                  end else if (w_cnt == c_ZERO) begin
                     w_done     = 1'b1;
                     w_phase_nx = c_IDLE;
                  end
               end
               default: w_phase_nx = c_IDLE;
            endcase
         end
         if (w_code != c_E_NONE) begin
            w_phase_nx = c_ERR;
            w_kick     = 1'b0;
            w_done     = 1'b0;
         end
      end else if (w_cnt == c_ZERO) begin
         // An all-off sample is the only safe resynchronisation point.
         w_phase_nx = c_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase    <= c_IDLE;
         r_prev     <= '0;
         r_lit      <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= c_E_NONE;
         r_kick     <= '0;
         r_cycle    <= '0;
      end else begin
         r_phase <= w_phase_nx;
         r_prev  <= w_cnt;
         r_lit   <= w_cnt;
         r_done  <= w_done;
         r_err   <= (w_code != c_E_NONE);
         if (w_code != c_E_NONE) r_err_code <= w_code;
         if (w_kick && (r_kick != '1))  r_kick  <= r_kick + CNT_W'(1);
         if (w_done && (r_cycle != '1)) r_cycle <= r_cycle + CNT_W'(1);
      end
   end

   assign mon_if.phase     = r_phase;
   assign mon_if.lit_cnt   = r_lit;
   assign mon_if.seq_done  = r_done;
   assign mon_if.err       = r_err;
   assign mon_if.err_code  = r_err_code;
   assign mon_if.kick_cnt  = r_kick;
   assign mon_if.cycle_cnt = r_cycle;

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_monitor.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_bound_flasher_monitor : directed self-checking bench for monitor   |
// | Rev 1.0  initial release                                              |
// +-----------------------------------------------------------------------+
module tb_bound_flasher_monitor;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   int   cur;
   int   seen_err;
   int   seen_done;
   logic [2:0] ph_first;
   logic [2:0] ph_last;

   bound_flasher_monitor_if #(.MAX_LED(16), .CNT_W(8)) mon ();

   bound_flasher_monitor #(.MAX_LED(16), .CNT_W(8)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .mon_if (mon.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "timeout");
   end

   function automatic logic [15:0] thermo(input int c);
      logic [16:0] t;
      t = (17'd1 << c) - 17'd1;
      return t[15:0];
   endfunction

   task automatic drive_raw(input logic [15:0] v);
      mon.led = v;
      @(posedge clk);
      #1;
      if (mon.err === 1'b1)      seen_err++;
      if (mon.seq_done === 1'b1) seen_done++;
   endtask

   task automatic drive(input int c);
      cur = c;
      drive_raw(thermo(c));
   endtask

   // Step one lamp at a time towards target, recording first and last phase.
   task automatic walk(input int target);
      bit first;
      first = 1'b1;
      while (cur != target) begin
         drive(cur + ((target > cur) ? 1 : -1));
         if (first) ph_first = mon.phase;
         ph_last = mon.phase;
         first = 1'b0;
      end
   endtask

   task automatic do_reset();
      mon.led = '0;
      cur = 0;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      seen_err = 0;
      seen_done = 0;
   endtask

   task automatic full_seq();
      walk(6); walk(0); walk(11); walk(5); walk(16); walk(0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mon.led = '0;
      #12;
      n_checks++; if (mon.phase !== 3'd0) begin n_errors++; $display("FAIL reset_phase: got %0d want 0", mon.phase); end
      n_checks++; if (mon.lit_cnt !== 5'd0) begin n_errors++; $display("FAIL reset_lit: got %0d want 0", mon.lit_cnt); end
      n_checks++; if ({mon.err, mon.seq_done, mon.err_code} !== 5'd0) begin n_errors++; $display("FAIL reset_flags: got %b want 00000", {mon.err, mon.seq_done, mon.err_code}); end
      n_checks++; if ({mon.kick_cnt, mon.cycle_cnt} !== 16'd0) begin n_errors++; $display("FAIL reset_cnts: got %h want 0000", {mon.kick_cnt, mon.cycle_cnt}); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_clean();
      do_reset();
      walk(6);
      n_checks++; if ({ph_first, ph_last} !== {3'd1, 3'd1}) begin n_errors++; $display("FAIL clean_up5: got %0d/%0d want 1/1", ph_first, ph_last); end
      n_checks++; if (mon.lit_cnt !== 5'd6) begin n_errors++; $display("FAIL clean_lit6: got %0d want 6", mon.lit_cnt); end
      walk(0);
      n_checks++; if ({ph_first, ph_last} !== {3'd2, 3'd2}) begin n_errors++; $display("FAIL clean_dn0a: got %0d/%0d want 2/2", ph_first, ph_last); end
      walk(11);
      n_checks++; if ({ph_first, ph_last} !== {3'd3, 3'd3}) begin n_errors++; $display("FAIL clean_up10: got %0d/%0d want 3/3", ph_first, ph_last); end
      walk(5);
      n_checks++; if ({ph_first, ph_last} !== {3'd4, 3'd4}) begin n_errors++; $display("FAIL clean_dn5: got %0d/%0d want 4/4", ph_first, ph_last); end
      walk(16);
      n_checks++; if ({ph_first, ph_last} !== {3'd5, 3'd5}) begin n_errors++; $display("FAIL clean_up15: got %0d/%0d want 5/5", ph_first, ph_last); end
      n_checks++; if (mon.lit_cnt !== 5'd16) begin n_errors++; $display("FAIL clean_lit16: got %0d want 16", mon.lit_cnt); end
      walk(1);
      n_checks++; if ({ph_first, ph_last} !== {3'd6, 3'd6}) begin n_errors++; $display("FAIL clean_dn0b: got %0d/%0d want 6/6", ph_first, ph_last); end
      n_checks++; if (mon.seq_done !== 1'b0) begin n_errors++; $display("FAIL clean_early_done: got %b want 0", mon.seq_done); end
      drive(0);
      n_checks++; if (mon.phase !== 3'd0) begin n_errors++; $display("FAIL clean_idle: got %0d want 0", mon.phase); end
      n_checks++; if (mon.seq_done !== 1'b1) begin n_errors++; $display("FAIL clean_done: got %b want 1", mon.seq_done); end
      n_checks++; if (mon.cycle_cnt !== 8'd1) begin n_errors++; $display("FAIL clean_cycle: got %0d want 1", mon.cycle_cnt); end
      drive(0);
      n_checks++; if ({mon.seq_done, mon.phase} !== 4'b0_000) begin n_errors++; $display("FAIL clean_idle_hold: got %b want 0000", {mon.seq_done, mon.phase}); end
      n_checks++; if (mon.kick_cnt !== 8'd0) begin n_errors++; $display("FAIL clean_kick: got %0d want 0", mon.kick_cnt); end
      n_checks++; if ({seen_err, seen_done} !== {32'd0, 32'd1}) begin n_errors++; $display("FAIL clean_pulses: err %0d done %0d want 0/1", seen_err, seen_done); end
   endtask

   task automatic test_kick10();
      do_reset();
      walk(6); walk(0); walk(8);
      n_checks++; if (mon.phase !== 3'd3) begin n_errors++; $display("FAIL k10_up10: got %0d want 3", mon.phase); end
      drive(7);
      n_checks++; if (mon.phase !== 3'd2) begin n_errors++; $display("FAIL k10_back: got %0d want 2", mon.phase); end
      n_checks++; if (mon.kick_cnt !== 8'd1) begin n_errors++; $display("FAIL k10_kick: got %0d want 1", mon.kick_cnt); end
      walk(0); walk(11);
      n_checks++; if ({ph_first, ph_last} !== {3'd3, 3'd3}) begin n_errors++; $display("FAIL k10_rerun: got %0d/%0d want 3/3", ph_first, ph_last); end
      walk(5); walk(16); walk(0);
      n_checks++; if ({mon.kick_cnt, mon.cycle_cnt} !== {8'd1, 8'd1}) begin n_errors++; $display("FAIL k10_cnts: kick %0d cycle %0d want 1/1", mon.kick_cnt, mon.cycle_cnt); end
      n_checks++; if ({seen_err, seen_done} !== {32'd0, 32'd1}) begin n_errors++; $display("FAIL k10_pulses: err %0d done %0d want 0/1", seen_err, seen_done); end
   endtask

   task automatic test_kick15();
      do_reset();
      walk(6); walk(0); walk(11); walk(5); walk(12);
      n_checks++; if (mon.phase !== 3'd5) begin n_errors++; $display("FAIL k15_up15: got %0d want 5", mon.phase); end
      walk(5);
      n_checks++; if ({ph_first, ph_last} !== {3'd4, 3'd4}) begin n_errors++; $display("FAIL k15_back: got %0d/%0d want 4/4", ph_first, ph_last); end
      walk(16);
      n_checks++; if ({ph_first, ph_last} !== {3'd5, 3'd5}) begin n_errors++; $display("FAIL k15_rerun: got %0d/%0d want 5/5", ph_first, ph_last); end
      walk(0);
      n_checks++; if ({mon.kick_cnt, mon.cycle_cnt} !== {8'd1, 8'd1}) begin n_errors++; $display("FAIL k15_cnts: kick %0d cycle %0d want 1/1", mon.kick_cnt, mon.cycle_cnt); end
      n_checks++; if (seen_err !== 0) begin n_errors++; $display("FAIL k15_noerr: got %0d err pulses want 0", seen_err); end
   endtask

   task automatic test_bad_patterns();
      do_reset();
      drive_raw(16'h0005);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b1, 3'd1, 3'd7}) begin n_errors++; $display("FAIL bad_nottherm: err/code/phase %b/%0d/%0d want 1/1/7", mon.err, mon.err_code, mon.phase); end
      drive(0);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b0, 3'd1, 3'd0}) begin n_errors++; $display("FAIL bad_resync: err/code/phase %b/%0d/%0d want 0/1/0", mon.err, mon.err_code, mon.phase); end
      walk(2);
      drive(4);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b1, 3'd2, 3'd7}) begin n_errors++; $display("FAIL bad_step: err/code/phase %b/%0d/%0d want 1/2/7", mon.err, mon.err_code, mon.phase); end
      drive(3);
      n_checks++; if ({mon.err, mon.phase} !== {1'b0, 3'd7}) begin n_errors++; $display("FAIL bad_errhold: err/phase %b/%0d want 0/7", mon.err, mon.phase); end
      drive(0);
      walk(3);
      drive(3);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b1, 3'd3, 3'd7}) begin n_errors++; $display("FAIL bad_stall: err/code/phase %b/%0d/%0d want 1/3/7", mon.err, mon.err_code, mon.phase); end
      drive(0);
   endtask

   task automatic test_turn_overrun();
      do_reset();
      walk(4);
      drive(3);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b1, 3'd5, 3'd7}) begin n_errors++; $display("FAIL turn_badturn: err/code/phase %b/%0d/%0d want 1/5/7", mon.err, mon.err_code, mon.phase); end
      drive(0);
      walk(6); walk(0); walk(11); walk(5);
      n_checks++; if ({mon.err, mon.phase} !== {1'b0, 3'd4}) begin n_errors++; $display("FAIL turn_dn5: err/phase %b/%0d want 0/4", mon.err, mon.phase); end
      drive(4);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b1, 3'd4, 3'd7}) begin n_errors++; $display("FAIL turn_overrun: err/code/phase %b/%0d/%0d want 1/4/7", mon.err, mon.err_code, mon.phase); end
      drive(0);
   endtask

   task automatic test_async_reset();
      do_reset();
      walk(6); walk(0); walk(7);
      n_checks++; if ({mon.phase, mon.lit_cnt} !== {3'd3, 5'd7}) begin n_errors++; $display("FAIL ar_pre: phase/lit %0d/%0d want 3/7", mon.phase, mon.lit_cnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({mon.phase, mon.lit_cnt, mon.err, mon.seq_done, mon.err_code, mon.kick_cnt, mon.cycle_cnt} !== 29'd0) begin n_errors++; $display("FAIL ar_async: phase %0d lit %0d err %b done %b code %0d", mon.phase, mon.lit_cnt, mon.err, mon.seq_done, mon.err_code); end
      #1;
      rst_n = 1'b1;
      seen_err = 0;
      seen_done = 0;
      drive_raw(16'h00FF);
      n_checks++; if ({mon.err, mon.err_code, mon.phase} !== {1'b1, 3'd2, 3'd7}) begin n_errors++; $display("FAIL ar_step: err/code/phase %b/%0d/%0d want 1/2/7", mon.err, mon.err_code, mon.phase); end
      drive(0);
      n_checks++; if (mon.phase !== 3'd0) begin n_errors++; $display("FAIL ar_idle: got %0d want 0", mon.phase); end
      full_seq();
      n_checks++; if ({mon.cycle_cnt, mon.err_code} !== {8'd1, 3'd2}) begin n_errors++; $display("FAIL ar_recover: cycle %0d code %0d want 1/2", mon.cycle_cnt, mon.err_code); end
   endtask

   task automatic test_saturation();
      do_reset();
      repeat (255) full_seq();
      n_checks++; if (mon.cycle_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_255: got %0d want 255", mon.cycle_cnt); end
      full_seq();
      n_checks++; if (mon.cycle_cnt !== 8'd255) begin n_errors++; $display("FAIL sat_hold: got %0d want 255", mon.cycle_cnt); end
      n_checks++; if ({seen_err, seen_done} !== {32'd0, 32'd256}) begin n_errors++; $display("FAIL sat_pulses: err %0d done %0d want 0/256", seen_err, seen_done); end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      cur = 0;
      seen_err = 0;
      seen_done = 0;
      ph_first = '0;
      ph_last = '0;
      test_reset();
      test_clean();
      test_kick10();
      test_kick15();
      test_bad_patterns();
      test_turn_overrun();
      test_async_reset();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
